// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: measurement sequencer for a single freq_det instance.
// Selects the detector channel, drops settling edges, accumulates NUM_MEAS
// half-period counts, then publishes avg/min/max and a tolerance verdict.
// Optional magnitude tracking is compiled in with `define FREQ_MEAS_MAG_EN.
//
// Handshake: start is a one-cycle request, accepted only in IDLE or DONE while
// abort is low; busy is high in SETTLE/ACCUM/EVAL; result_valid is a one-cycle
// pulse that qualifies avg/min_cnt/max_cnt/pass/timeout, which then hold until
// the next result or reset. abort cancels a busy run with no result pulse.
module freq_meas_ctrl #(
  parameter int CNT_W         = 10,
  parameter int LOG2_NUM_MEAS = 3,
  parameter int SETTLE_EDGES  = 2,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int CHAN_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAN_W-1:0] chan_req,
  input  logic [CNT_W-1:0]  expected,
  input  logic [CNT_W-1:0]  tol,
  input  logic [CNT_W-1:0]  det_counter,
  input  logic              det_done,
  input  logic [7:0]        det_magnitude,
  output logic [CHAN_W-1:0] chan_sel,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  avg,
  output logic [CNT_W-1:0]  min_cnt,
  output logic [CNT_W-1:0]  max_cnt,
  output logic              pass,
  output logic              timeout,
`ifdef FREQ_MEAS_MAG_EN
  input  logic [7:0]        mag_floor,
  output logic [7:0]        mag_min,
  output logic [7:0]        mag_max,
`endif
  output logic [2:0]        state_dbg
);

  localparam int NUM_MEAS = 1 << LOG2_NUM_MEAS;
  localparam int SUM_W    = CNT_W + LOG2_NUM_MEAS;
  localparam int TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SET_W    = $clog2(SETTLE_EDGES + 1);
  localparam int EDGE_W   = (SET_W > LOG2_NUM_MEAS + 1) ? SET_W : LOG2_NUM_MEAS + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACCUM  = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [SUM_W-1:0]   sum;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   min_reg, max_reg;
  logic [CNT_W-1:0]   exp_q, tol_q;
  logic [CNT_W-1:0]   avg_int;
  logic [CNT_W:0]     avg_ext, exp_ext, diff;
  logic               cnt_ok, pass_int;
  logic               in_run, start_ok, settle_last, accum_last;
  logic               tmr_max, tmr_expire, timeout_evt;
`ifdef FREQ_MEAS_MAG_EN
  logic [7:0]         mag_min_reg, mag_max_reg;
`endif

  assign state_dbg   = state;
  assign in_run      = (state == SETTLE) || (state == ACCUM);
  assign busy        = in_run || (state == EVAL);
  assign start_ok    = start && !abort && ((state == IDLE) || (state == DONE));
  assign settle_last = (edge_cnt == EDGE_W'(SETTLE_EDGES - 1));
  assign accum_last  = (edge_cnt == EDGE_W'(NUM_MEAS - 1));
  assign tmr_max     = (timer == TMR_W'(TIMEOUT_CYC - 1));
  // A det_done in the expiry cycle wins over the timeout.
  assign tmr_expire  = in_run && !det_done && tmr_max;
  assign timeout_evt = tmr_expire && !abort;

  // Average is the truncated sum; the deviation is taken one bit wider so the
  // subtraction never wraps.
  assign avg_int = sum[SUM_W-1:LOG2_NUM_MEAS];
  assign avg_ext = {1'b0, avg_int};
  assign exp_ext = {1'b0, exp_q};
  assign diff    = (avg_ext >= exp_ext) ? (avg_ext - exp_ext) : (exp_ext - avg_ext);
  assign cnt_ok  = (diff <= {1'b0, tol_q});
`ifdef FREQ_MEAS_MAG_EN
  assign pass_int = cnt_ok && ((mag_max_reg - mag_min_reg) >= mag_floor);
`else
  assign pass_int = cnt_ok;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: abort dominates every busy state and a same-cycle start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start_ok) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (abort)                        state_nxt = IDLE;
        else if (det_done && settle_last) state_nxt = ACCUM;
        else if (tmr_expire)              state_nxt = IDLE;
      end
      ACCUM: begin
        if (abort)                       state_nxt = IDLE;
        else if (det_done && accum_last) state_nxt = EVAL;
        else if (tmr_expire)             state_nxt = IDLE;
      end
      EVAL: begin
        if (abort) state_nxt = IDLE;
        else       state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run setup, accumulation, timeout timer and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_sel     <= '0;
      exp_q        <= '0;
      tol_q        <= '0;
      sum          <= '0;
      edge_cnt     <= '0;
      timer        <= '0;
      min_reg      <= '0;
      max_reg      <= '0;
      avg          <= '0;
      min_cnt      <= '0;
      max_cnt      <= '0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
`ifdef FREQ_MEAS_MAG_EN
      mag_min_reg  <= 8'hFF;
      mag_max_reg  <= 8'h00;
      mag_min      <= 8'h00;
      mag_max      <= 8'h00;
`endif
    end else begin
      result_valid <= 1'b0;
      if (start_ok) begin
        chan_sel <= chan_req;
        exp_q    <= expected;
        tol_q    <= tol;
        sum      <= '0;
        edge_cnt <= '0;
        timer    <= '0;
        min_reg  <= '1;
        max_reg  <= '0;
        timeout  <= 1'b0;
`ifdef FREQ_MEAS_MAG_EN
        mag_min_reg <= 8'hFF;
        mag_max_reg <= 8'h00;
`endif
      end else if (in_run) begin
        if (det_done)      timer <= '0;
        else if (!tmr_max) timer <= timer + 1'b1;
        if (det_done) begin
          if (state == SETTLE) begin
            // Restart the edge count so ACCUM counts accepted pulses from zero.
            edge_cnt <= settle_last ? '0 : edge_cnt + 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
            sum      <= sum + SUM_W'(det_counter);
            if (det_counter <= min_reg) min_reg <= det_counter;
            if (det_counter >= max_reg) max_reg <= det_counter;
`ifdef FREQ_MEAS_MAG_EN
            if (det_magnitude <= mag_min_reg) mag_min_reg <= det_magnitude;
            if (det_magnitude >= mag_max_reg) mag_max_reg <= det_magnitude;
`endif
          end
        end
        if (timeout_evt) begin
          timeout      <= 1'b1;
          pass         <= 1'b0;
          avg          <= '0;
          min_cnt      <= '0;
          max_cnt      <= '0;
          result_valid <= 1'b1;
`ifdef FREQ_MEAS_MAG_EN
          mag_min      <= 8'h00;
          mag_max      <= 8'h00;
`endif
        end
      end else if ((state == EVAL) && !abort) begin
        // Results land with the DONE cycle so result_valid qualifies them.
        avg          <= avg_int;
        min_cnt      <= min_reg;
        max_cnt      <= max_reg;
        pass         <= pass_int;
        result_valid <= 1'b1;
`ifdef FREQ_MEAS_MAG_EN
        mag_min      <= mag_min_reg;
        mag_max      <= mag_max_reg;
`endif
      end
    end
  end

  // det_magnitude only feeds the optional magnitude tracker.
`ifndef FREQ_MEAS_MAG_EN
  logic unused_mag;
  assign unused_mag = ^det_magnitude;
`endif

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed + randomized bench for freq_meas_ctrl with a
// reference model computed from accepted counts using plain arithmetic.
`timescale 1ns/1ps
module tb_freq_meas_ctrl;

  localparam int CNT_W         = 10;
  localparam int LOG2_NUM_MEAS = 3;
  localparam int NUM_MEAS      = 8;
  localparam int SETTLE_EDGES  = 2;
  localparam int TIMEOUT_CYC   = 4096;
  localparam int CHAN_W        = 2;
  localparam int TOTAL         = SETTLE_EDGES + NUM_MEAS;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst, start, abort, det_done, pass, timeout;
  logic              busy, result_valid;
  logic [CHAN_W-1:0] chan_req, chan_sel;
  logic [CNT_W-1:0]  expected, tol, det_counter, avg, min_cnt, max_cnt;
  logic [7:0]        det_magnitude;
  logic [2:0]        state_dbg;
`ifdef FREQ_MEAS_MAG_EN
  logic [7:0]        mag_floor, mag_min, mag_max;
`endif

  always #5 clk = ~clk;

  freq_meas_ctrl #(
    .CNT_W(CNT_W), .LOG2_NUM_MEAS(LOG2_NUM_MEAS), .SETTLE_EDGES(SETTLE_EDGES),
    .TIMEOUT_CYC(TIMEOUT_CYC), .CHAN_W(CHAN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_req(chan_req),
    .expected(expected), .tol(tol), .det_counter(det_counter), .det_done(det_done),
    .det_magnitude(det_magnitude), .chan_sel(chan_sel), .busy(busy),
    .result_valid(result_valid), .avg(avg), .min_cnt(min_cnt), .max_cnt(max_cnt),
    .pass(pass), .timeout(timeout),
`ifdef FREQ_MEAS_MAG_EN
    .mag_floor(mag_floor), .mag_min(mag_min), .mag_max(mag_max),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  int cnt_arr [TOTAL];
  int mag_arr [TOTAL];
  int m_chan, m_avg, m_min, m_max, m_pass, m_timeout, m_mag_min, m_mag_max;
  int floor_v = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected result of a complete run: mean/min/max over accepted pulses only.
  task automatic model_result(input int exp_v, input int tol_v);
    int sum, lo, hi, mlo, mhi, d;
    sum = 0; lo = 1 << 30; hi = -1; mlo = 1 << 30; mhi = -1;
    for (int i = SETTLE_EDGES; i < TOTAL; i++) begin
      sum += cnt_arr[i];
      if (cnt_arr[i] < lo) lo = cnt_arr[i];
      if (cnt_arr[i] > hi) hi = cnt_arr[i];
      if (mag_arr[i] < mlo) mlo = mag_arr[i];
      if (mag_arr[i] > mhi) mhi = mag_arr[i];
    end
    m_avg = sum / NUM_MEAS;
    m_min = lo;
    m_max = hi;
    d = m_avg - exp_v;
    if (d < 0) d = -d;
    m_pass = (d <= tol_v) ? 1 : 0;
`ifdef FREQ_MEAS_MAG_EN
    if ((mhi - mlo) < floor_v) m_pass = 0;
`endif
    m_mag_min = mlo;
    m_mag_max = mhi;
    m_timeout = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_chan_sel"}, 32'(chan_sel), m_chan);
    chk({tag, "_avg"}, 32'(avg), m_avg);
    chk({tag, "_min"}, 32'(min_cnt), m_min);
    chk({tag, "_max"}, 32'(max_cnt), m_max);
    chk({tag, "_pass"}, 32'(pass), m_pass);
    chk({tag, "_timeout"}, 32'(timeout), m_timeout);
`ifdef FREQ_MEAS_MAG_EN
    chk({tag, "_mag_min"}, 32'(mag_min), m_mag_min);
    chk({tag, "_mag_max"}, 32'(mag_max), m_mag_max);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input int chan, input int exp_v, input int tol_v);
    start = 1'b1; chan_req = CHAN_W'(chan); expected = CNT_W'(exp_v); tol = CNT_W'(tol_v);
    step();
    start = 1'b0;
    chan_req = CHAN_W'($urandom); expected = CNT_W'($urandom); tol = CNT_W'($urandom);
  endtask

  // One det_done pulse after 'gap' idle cycles.
  task automatic pulse(input int idx, input int gap);
    repeat (gap) begin
      det_counter = CNT_W'($urandom);
      step();
    end
    det_done = 1'b1; det_counter = CNT_W'(cnt_arr[idx]); det_magnitude = 8'(mag_arr[idx]);
    step();
    det_done = 1'b0;
  endtask

  // Full measurement; long_idx selects a pulse preceded by the longest legal gap,
  // poke raises a competing start while busy.
  task automatic run_meas(input string tag, input int chan, input int exp_v, input int tol_v,
                          input int long_idx, input bit poke);
    do_start(chan, exp_v, tol_v);
    m_chan = chan;
    chk({tag, "_busy_start"}, 32'(busy), 1);
    for (int i = 0; i < TOTAL; i++) begin
      int gap;
      gap = (i == long_idx) ? TIMEOUT_CYC - 1 : $urandom_range(0, 3);
      if (poke && i == SETTLE_EDGES + 1) begin
        start = 1'b1; chan_req = CHAN_W'(chan + 1); expected = '0; tol = '0;
        step();
        start = 1'b0;
      end
      pulse(i, gap);
    end
    chk({tag, "_rv_eval"}, 32'(result_valid), 0);
    chk({tag, "_busy_eval"}, 32'(busy), 1);
    step();
    chk({tag, "_rv_done"}, 32'(result_valid), 1);
    chk({tag, "_busy_done"}, 32'(busy), 0);
    model_result(exp_v, tol_v);
    check_outputs(tag);
    step();
    chk({tag, "_rv_single"}, 32'(result_valid), 0);
  endtask

  task automatic fill_const(input int c, input int m);
    for (int i = 0; i < TOTAL; i++) begin
      cnt_arr[i] = c;
      mag_arr[i] = m;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, base, ev, bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; det_done = 1'b0;
    chan_req = '0; expected = '0; tol = '0; det_counter = '0; det_magnitude = '0;
`ifdef FREQ_MEAS_MAG_EN
    mag_floor = '0;
`endif
    m_chan = 0; m_avg = 0; m_min = 0; m_max = 0; m_pass = 0; m_timeout = 0;
    m_mag_min = 0; m_mag_max = 0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv", 32'(result_valid), 0);
    check_outputs("rst");
    rst = 1'b0;
    step();

    // All ten pulses at 100; the first two are settle edges.
    fill_const(100, 8'h80);
    run_meas("tp_100", 2, 100, 2, -1, 1'b0);

    // Alternating 98/103 with junk settle counts; competing start is ignored.
    for (int i = 0; i < TOTAL; i++) begin
      cnt_arr[i] = (i < SETTLE_EDGES) ? 900 : ((i % 2) ? 103 : 98);
      mag_arr[i] = $urandom_range(0, 255);
    end
    run_meas("alt_pass", 1, 100, 2, -1, 1'b1);
    run_meas("alt_fail", 3, 97, 2, -1, 1'b0);

    // Extreme counts, and a gap that expires exactly as det_done arrives.
    for (int i = 0; i < TOTAL; i++) begin
      cnt_arr[i] = (i % 2) ? 1023 : 0;
      mag_arr[i] = $urandom_range(0, 255);
    end
    run_meas("extreme", 0, 511, 0, 0, 1'b0);

    // Randomized runs clustered so both verdicts occur.
    for (int r = 0; r < 6; r++) begin
      base = $urandom_range(0, 1000);
      for (int i = 0; i < TOTAL; i++) begin
        cnt_arr[i] = (i < SETTLE_EDGES) ? $urandom_range(0, 1023) : base + $urandom_range(0, 23);
        mag_arr[i] = $urandom_range(0, 255);
      end
      ev = base + $urandom_range(0, 23);
      run_meas("rand", $urandom_range(0, 3), ev, $urandom_range(0, 6),
               (r == 2) ? SETTLE_EDGES + 3 : -1, 1'b0);
    end

    // Timeout: no det_done at all.
    do_start(1, 200, 5);
    m_chan = 1;
    k = 0; bad = 0;
    while (result_valid !== 1'b1 && k < TIMEOUT_CYC + 20) begin
      if (busy !== 1'b1) bad = 1;
      step();
      k++;
    end
    chk("to_cycles", k, TIMEOUT_CYC);
    chk("to_busy_during", bad, 0);
    chk("to_busy_after", 32'(busy), 0);
    m_avg = 0; m_min = 0; m_max = 0; m_pass = 0; m_timeout = 1; m_mag_min = 0; m_mag_max = 0;
    check_outputs("to");
    step();
    chk("to_rv_single", 32'(result_valid), 0);

    // Normal run, then an abort after three accepted measurements.
    fill_const(300, 8'h40);
    run_meas("pre_abort", 2, 300, 1, -1, 1'b0);
    do_start(3, 10, 10);
    m_chan = 3; m_timeout = 0;
    for (int i = 0; i < SETTLE_EDGES + 3; i++) pulse(i, $urandom_range(0, 2));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rv", 32'(result_valid), 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      det_done = i[0];
      det_counter = CNT_W'($urandom);
      step();
      if (result_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    det_done = 1'b0;
    chk("abort_quiet", bad, 0);
    check_outputs("abort_hold");

    // start and abort together from IDLE: start is dropped.
    start = 1'b1; abort = 1'b1; chan_req = 2'd1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    step();
    chk("sa_busy2", 32'(busy), 0);
    chk("sa_chan", 32'(chan_sel), m_chan);

    // Asynchronous reset in the middle of ACCUM.
    fill_const(555, 8'h10);
    do_start(2, 555, 0);
    for (int i = 0; i < SETTLE_EDGES + 4; i++) pulse(i, $urandom_range(0, 2));
    #2 rst = 1'b1;
    #1;
    m_chan = 0; m_avg = 0; m_min = 0; m_max = 0; m_pass = 0; m_timeout = 0;
    m_mag_min = 0; m_mag_max = 0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_rv", 32'(result_valid), 0);
    check_outputs("rst_mid");
    step();
    rst = 1'b0;
    step();
    run_meas("post_rst", 1, 550, 5, -1, 1'b0);

`ifdef FREQ_MEAS_MAG_EN
    floor_v = 8'h80;
    mag_floor = 8'h80;
    for (int i = 0; i < TOTAL; i++) begin
      cnt_arr[i] = 100;
      mag_arr[i] = (i % 2) ? 8'hE0 : 8'h20;
    end
    run_meas("mag_toggle", 0, 100, 0, -1, 1'b0);
    fill_const(100, 8'h20);
    run_meas("mag_flat", 0, 100, 0, -1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
